// File: rtl/data_memory.sv
// Word-addressed data memory for the single-cycle CPU memory stage.
// Synchronous full-word write, combinational read, async active-low clear of every word.
module data_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  write_en_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: this array is built from flops, not a RAM macro, so it can carry the
    // async clear. Every word is reset in the same process that writes it,
    // which avoids a second driver on mem. Reset takes priority over any write.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (write_en_in) begin
            mem[addr_in] <= data_in;
        end
    end

    // A load completes in the same cycle. A same-address store becomes visible only after the edge.
    assign data_out = mem[addr_in];

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed steps plus randomized load/store traffic,
// compared against an array model of the memory.
module tb_data_memory;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NW = 256;

    logic          clk_in;
    logic          rst_n_in;
    logic          write_en_in;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;

    int vectors;
    int miscompares;

    logic [DW-1:0] model [NW];

    data_memory #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (NW)
    ) dut (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .write_en_in(write_en_in),
        .addr_in    (addr_in),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [DW-1:0] observed,
                         input logic [DW-1:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NW; i++) model[i] = '0;
    endtask

    // Combinational read probe: move the address and look after a small settle time.
    task automatic probe(input string tag, input logic [AW-1:0] a);
        addr_in = a;
        #1;
        check(tag, data_out, model[a]);
    endtask

    // One-clock store: inputs applied after a falling edge, captured on the next rising edge.
    task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk_in);
        addr_in     = a;
        data_in     = d;
        write_en_in = 1'b1;
        @(posedge clk_in);
        model[a] = d;
        @(negedge clk_in);
        write_en_in = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        logic          rw;

        vectors     = 0;
        miscompares = 0;
        model_clear();

        rst_n_in    = 1'b0;
        write_en_in = 1'b0;
        addr_in     = '0;
        data_in     = '0;
        #50;
        check("in_reset_addr0", data_out, model[0]);
        #50;
        rst_n_in = 1'b1;

        probe("reset_addr_0", 8'd0);
        probe("reset_addr_1", 8'd1);
        probe("reset_addr_128", 8'd128);
        probe("reset_addr_255", 8'd255);

        store(8'h05, 32'hDEADBEEF);
        probe("basic_addr5", 8'h05);
        probe("basic_addr4", 8'h04);
        probe("basic_addr6", 8'h06);
        probe("comb_read_back_addr5", 8'h05);

        addr_in = 8'h05;
        data_in = 32'h12345678;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        probe("wr_disabled_addr5", 8'h05);

        store(8'h00, 32'hFFFFFFFF);
        store(8'hFF, 32'h80000001);
        probe("bound_addr00", 8'h00);
        probe("bound_addrFF", 8'hFF);
        store(8'h00, 32'h0000A5A5);
        probe("overwrite_addr00", 8'h00);
        probe("overwrite_keeps_FF", 8'hFF);

        store(8'h10, 32'h11111111);
        @(negedge clk_in);
        addr_in     = 8'h10;
        data_in     = 32'h22222222;
        write_en_in = 1'b1;
        #1;
        check("same_cycle_before_edge", data_out, model[8'h10]);
        @(posedge clk_in);
        model[8'h10] = 32'h22222222;
        #1;
        check("same_cycle_after_edge", data_out, model[8'h10]);
        @(negedge clk_in);
        write_en_in = 1'b0;

        // Random load/store traffic; each op checks the pre-edge value, the post-edge value,
        // and one unrelated address read combinationally.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk_in);
            ra = AW'($urandom_range(0, NW - 1));
            rd = $urandom;
            rw = 1'($urandom_range(0, 1));
            addr_in     = ra;
            data_in     = rd;
            write_en_in = rw;
            #1;
            check("rand_pre_edge", data_out, model[ra]);
            @(posedge clk_in);
            if (rw) model[ra] = rd;
            #1;
            check("rand_post_edge", data_out, model[ra]);
            write_en_in = 1'b0;
            probe("rand_other_addr", AW'($urandom_range(0, NW - 1)));
        end

        // Async reset between edges while a store is pending.
        @(negedge clk_in);
        addr_in     = 8'h10;
        #1;
        check("pre_reset_addr10", data_out, model[8'h10]);
        addr_in     = 8'h33;
        data_in     = 32'hCAFEF00D;
        write_en_in = 1'b1;
        #1;
        rst_n_in = 1'b0;
        model_clear();
        #1;
        check("async_reset_immediate", data_out, model[8'h33]);
        @(posedge clk_in);
        #1;
        check("write_blocked_in_reset", data_out, model[8'h33]);
        @(negedge clk_in);
        write_en_in = 1'b0;
        #1;
        rst_n_in = 1'b1;
        probe("post_reset_addr00", 8'h00);
        probe("post_reset_addr05", 8'h05);
        probe("post_reset_addr10", 8'h10);
        probe("post_reset_addrFF", 8'hFF);
        probe("post_reset_pending33", 8'h33);
        for (int i = 0; i < NW; i += 17) begin
            probe("post_reset_sweep", AW'(i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Word-addressed data memory for the single-cycle ARM-style CPU datapath; serves load/store instructions from the memory stage.
- 256 words x 32 bits, implemented as a register array.
- Synchronous write, combinational (asynchronous) read, so a load completes in the same cycle its address is presented.
- Asynchronous active-low reset clears the entire array.

Parameters:
- DATA_WIDTH, 32, width of each word and of data_in/data_out.
- ADDR_WIDTH, 8, width of addr_in.
- DEPTH, 256 (2**ADDR_WIDTH), number of words stored.

Ports:
- clk_in  input  1  system clock; all writes occur on its rising edge.
- rst_n_in  input  1  reset, asynchronous and active-low; clears every word to 0.
- write_en_in  input  1  write enable; 1 = store data_in at addr_in on the next rising clk_in edge.
- addr_in  input  ADDR_WIDTH  word index (not a byte address); selects both the read and the write location.
- data_in  input  DATA_WIDTH  store data.
- data_out  output  DATA_WIDTH  load data, always equal to mem[addr_in].

Behaviour:
- Storage: array mem[0..DEPTH-1] of DATA_WIDTH bits.
- Reset:
  - rst_n_in = 0 immediately (no clock needed) forces every mem word to 0.
  - data_out therefore reads 0 for any addr_in while reset is asserted and after release until written.
  - Reset has priority over write: a write attempted while rst_n_in = 0 is discarded.
  - Reset asserted mid-operation wipes all prior contents.
- Write:
  - On a rising clk_in edge with rst_n_in = 1 and write_en_in = 1, mem[addr_in] <= data_in.
  - Exactly one word is modified per edge; all other words hold.
  - write_en_in = 0 means no change.
  - No byte enables; writes are always full-word.
- Read:
  - Purely combinational: data_out = mem[addr_in], with zero-cycle latency after addr_in changes.
  - No read enable; data_out is always driven.
- Write/read same address in the same cycle: before the edge, data_out shows the old content. After the edge it shows data_in (write-first visible from the next delta after the edge). No bypass of data_in to data_out before the edge.
- Addressing: addr_in covers the full 0..255 range, so there are no out-of-range cases and no wrap logic. Addresses 0 and 255 are ordinary locations.
- No handshake, no stall, no error outputs.
- Unknown (X) values on write_en_in must not be treated as a write in synthesis intent; behaviour under X is not guaranteed.

Test Plan:
- Reset: hold rst_n_in = 0 for 100 ns with write_en_in = 0, then release. Sweep addr_in over 0, 1, 128, 255 -> data_out = 0x00000000 at every address.
- Basic write/read:
  - Write 0xDEADBEEF to addr 0x05 (write_en_in = 1 for one clock), then drop write_en_in -> data_out = 0xDEADBEEF at addr 5, and 0x00000000 at addr 4 and 6.
  - Combinational read: changing addr_in reflects the new word without waiting for a clock edge.
- Write disabled: with write_en_in = 0, data_in = 0x12345678, addr 0x05, clock several edges -> addr 5 still reads 0xDEADBEEF.
- Boundaries and overwrite:
  - Write 0xFFFFFFFF to addr 0x00 and 0x80000001 to addr 0xFF -> both read back exactly.
  - Overwrite addr 0x00 with 0x0000A5A5 -> reads 0x0000A5A5, and addr 0xFF is unchanged.
- Same-cycle read/write: addr = 0x10 holding 0x11111111. Set data_in = 0x22222222, write_en_in = 1 mid-cycle -> data_out = 0x11111111 before the edge and 0x22222222 after it.
- Async reset mid-operation: after the writes above, pulse rst_n_in low between clock edges with write_en_in = 1 -> data_out goes to 0 immediately without a clock edge. All previously written addresses (0x00, 0x05, 0x10, 0xFF) read 0 after release, and the write pending during reset did not occur.
